// File: rtl/mem_port_arbiter.sv
// Shares one single-port block RAM between the CPU instruction and data ports.
// Grants at most one access per cycle and returns responses in grant order.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int WORD_ADDR   = 1,
  parameter int ARB_MODE    = 0,
  parameter int MAX_WAIT    = 4
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_we,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int DEPTH  = 1 + MEM_LATENCY;
  localparam int WAIT_W = 4;

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_rr_inst_last;
  logic [DEPTH-1:0]  r_tag_vld;
  logic [DEPTH-1:0]  r_tag_data;

  logic              w_both;
  logic              w_inst_win;
  logic              w_any_gnt;
  logic              w_rsp_vld;
  logic              w_rsp_data;
  logic [ADDR_W-1:0] w_inst_maddr;
  logic [ADDR_W-1:0] w_data_maddr;

  // Only the request inputs and registered state feed the grants, never a grant.
  always_comb begin
    w_both     = inst_req && data_req;
    w_inst_win = 1'b0;
    inst_gnt   = 1'b0;
    data_gnt   = 1'b0;
    if (ARB_MODE == 1) w_inst_win = !r_rr_inst_last;
    else               w_inst_win = (r_wait_cnt == WAIT_W'(MAX_WAIT));
    if (!areset) begin
      if (w_both) begin
        inst_gnt = w_inst_win;
        data_gnt = !w_inst_win;
      end else begin
        inst_gnt = inst_req;
        data_gnt = data_req;
      end
    end
  end

  assign w_any_gnt    = inst_gnt || data_gnt;
  assign w_inst_maddr = (WORD_ADDR != 0) ? (inst_addr >> 2) : inst_addr;
  assign w_data_maddr = (WORD_ADDR != 0) ? (data_addr >> 2) : data_addr;
  assign w_rsp_vld    = r_tag_vld[DEPTH-1];
  assign w_rsp_data   = r_tag_data[DEPTH-1];

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wait_cnt     <= '0;
      r_rr_inst_last <= 1'b0;
    end else begin
      if (!inst_req || inst_gnt)                  r_wait_cnt <= '0;
      else if (r_wait_cnt != WAIT_W'(MAX_WAIT))   r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_both) r_rr_inst_last <= inst_gnt;
    end
  end

  // Memory command: address and write data hold when idle, enables drop.
  always_ff @(posedge aclk) begin
    if (areset) begin
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= w_any_gnt;
      mem_we <= data_gnt ? data_we : '0;
      if (inst_gnt) begin
        mem_addr  <= w_inst_maddr;
        mem_wdata <= '0;
      end else if (data_gnt) begin
        mem_addr  <= w_data_maddr;
        mem_wdata <= data_wdata;
      end
    end
  end

  // Tag stage k is valid k+1 cycles after the grant; the last stage lines up with mem_rdata.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_tag_vld   <= '0;
      r_tag_data  <= '0;
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
      inst_rdata  <= '0;
      data_rdata  <= '0;
    end else begin
      r_tag_vld   <= {r_tag_vld[DEPTH-2:0], w_any_gnt};
      r_tag_data  <= {r_tag_data[DEPTH-2:0], data_gnt};
      inst_rvalid <= w_rsp_vld && !w_rsp_data;
      data_rvalid <= w_rsp_vld && w_rsp_data;
      if (w_rsp_vld && !w_rsp_data) inst_rdata <= mem_rdata;
      if (w_rsp_vld && w_rsp_data)  data_rdata <= mem_rdata;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port block RAM between the CPU's instruction port and data port, so both can be backed by one memory.
- Each requester uses a req/gnt handshake and gets a one-cycle response strobe carrying read data.
- Issues at most one memory access per cycle, with registered memory outputs and a fixed memory read latency.
- Sits between cpu_top and the BRAM.

Parameters:
- ADDR_W, 32, requester and memory address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MEM_LATENCY, 1, cycles from mem_en sampled to mem_rdata valid; legal range 1..4
- WORD_ADDR, 1, 1: mem_addr = requester byte address >> 2; 0: address passed unchanged
- ARB_MODE, 0, 0: data priority with starvation guard; 1: round-robin
- MAX_WAIT, 4, data-priority mode only: consecutive cycles inst may lose before it is forced to win; range 1..15

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous, active-high reset
- inst_req  in  1  instruction request; held with inst_addr until inst_gnt
- inst_addr  in  ADDR_W  instruction byte address
- inst_gnt  out  1  request accepted this cycle (combinational)
- inst_rvalid  out  1  one-cycle response strobe
- inst_rdata  out  DATA_W  read data, valid with inst_rvalid
- data_req  in  1  data request; held with address/wdata/we until data_gnt
- data_addr  in  ADDR_W  data byte address
- data_wdata  in  DATA_W  store data
- data_we  in  DATA_W/8  byte write enables; 0 = read
- data_gnt  out  1  request accepted this cycle (combinational)
- data_rvalid  out  1  one-cycle response strobe (reads and writes)
- data_rdata  out  DATA_W  read data, valid with data_rvalid; don't-care for writes
- mem_en  out  1  memory enable (registered)
- mem_we  out  DATA_W/8  memory byte write enables (registered)
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset
  - On areset high at a clock edge: mem_en, mem_we, mem_addr, mem_wdata, both rvalid, both rdata, the round-robin pointer, the wait counter and every in-flight tag clear to 0.
  - In-flight accesses are discarded: no rvalid for any of them after reset.
  - inst_gnt and data_gnt are forced 0 while areset is high.
- Arbitration (combinational, each cycle)
  - Only inst_req high: inst_gnt=1. Only data_req high: data_gnt=1. Neither: no grant.
  - Both high, ARB_MODE=0: data wins, unless wait_cnt==MAX_WAIT, then inst wins.
  - Both high, ARB_MODE=1: the port not granted most recently wins. Pointer resets to favour inst; it updates only on a contended grant.
  - gnt never depends on gnt, so there is no combinational loop. At most one gnt per cycle.
- Wait counter (ARB_MODE=0)
  - Increments when inst_req=1 and inst_gnt=0, saturating at MAX_WAIT.
  - Clears on inst_gnt or when inst_req=0.
- Issue
  - The grant cycle registers the winner's command into mem_*: mem_en=1, mem_we=data_we (inst is always 0), mem_addr = translated address, mem_wdata = data_wdata (0 for inst).
  - With no grant: mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their values.
- Response pipeline
  - A tag shift register {valid, owner} of depth 1+MEM_LATENCY tracks each grant.
  - The owner's rvalid pulses exactly 1+MEM_LATENCY+1 edges after the grant edge, registered. This is grant cycle N → rvalid in cycle N+2+MEM_LATENCY; for MEM_LATENCY=1, grant in cycle 0 gives rvalid in cycle 3.
  - rdata captures mem_rdata in the same registered stage.
  - Writes also get rvalid, acting as a write acknowledge.
- Throughput and ordering
  - Back-to-back grants every cycle are supported; responses return in grant order with no bubbles.
  - There is no response backpressure: requesters must accept rvalid when it arrives.
- Holding rules
  - A requester that drops req before gnt simply loses its slot; no error.
  - Changing addr/wdata/we while req=1 and gnt=0 is allowed; the values sampled in the gnt cycle are used.
- Simultaneous events
  - Reset and a grant in the same cycle: reset wins, no gnt, nothing issued.
  - A response strobe and a new grant for the same port in the same cycle are independent and both occur.

Test Plan:
1. Single inst read, MEM_LATENCY=1: inst_req with inst_addr=0x0000_0010 in cycle 0 → inst_gnt in cycle 0; mem_en=1, mem_addr=0x4, mem_we=0 in cycle 1; inst_rvalid=1 with inst_rdata = memory word 4 in cycle 3, one cycle only.
2. Data write then read: write 0xDEADBEEF, data_we=4'hF, to 0x20 → data_rvalid ack; then read 0x20 → data_rdata=0xDEADBEEF.
   - Also with data_we=4'h1 and wdata 0x000000AA: only byte 0 changes, read returns 0xDEADBEAA.
3. Contention, ARB_MODE=0, MAX_WAIT=4: both req held high continuously → data granted 4 cycles, inst granted 5th cycle, pattern repeats (4 data, 1 inst); wait counter clears after each inst grant.
4. Contention, ARB_MODE=1: both req held high → grants alternate inst, data, inst, data…; responses return in grant order with correct owner and data.
5. Streaming, MEM_LATENCY=3: data_req high 8 consecutive cycles over addresses 0x0,0x4,…,0x1C → 8 consecutive grants; 8 consecutive data_rvalid starting 5 cycles after the first grant, data matching each address in order.
6. Reset mid-flight: grant two reads, assert areset for 1 cycle before their responses → no rvalid for either; mem_en=0 and all outputs 0 after reset; a new request after reset completes normally.
